// File: rtl/y86_instr_encoder_if.sv
// Instruction-field input and byte-stream output of the Y86-64 encoder.
// "master" is the side that supplies instructions and sinks bytes.
// "slave" is the encoder itself.
interface y86_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode;
  logic [3:0]  in_ifun;
  logic [3:0]  in_rA;
  logic [3:0]  in_rB;
  logic [63:0] in_valC;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic [63:0] out_addr;
  logic        out_last;

  modport master (
    output in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC, out_ready,
    input  in_ready, out_valid, out_byte, out_addr, out_last
  );

  modport slave (
    input  in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC, out_ready,
    output in_ready, out_valid, out_byte, out_addr, out_last
  );
endinterface

// File: rtl/y86_instr_encoder.sv
// Y86-64 instruction encoder.
// It accepts decoded instruction fields and emits the byte encoding of the
// instruction, one byte per cycle, with a running byte address.
// An instruction that would run past the end of memory is rejected before any
// byte of it is emitted, so the address never passes MEM_BYTES.
module y86_instr_encoder #(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int unsigned MEM_BYTES = 65
) (
  input  logic                 clock,
  input  logic                 reset_n,
  y86_instr_encoder_if.slave   bus,
  output logic                 busy,
  output logic [1:0]           stat,
  output logic [31:0]          instr_count
);

  typedef enum logic [1:0] {IDLE, EMIT, HALTED, ERROR} state_t;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  // Encoded length in bytes for each icode. Invalid codes return 0.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      4'h0, 4'h1, 4'h9:             instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:       instr_len = 4'd2;
      4'h7, 4'h8:                   instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:             instr_len = 4'd10;
      default:                      instr_len = 4'd0;
    endcase
  endfunction

  // Returns 1 when the instruction carries an {rA, rB} byte after the opcode.
  function automatic logic has_regs(input logic [3:0] icode);
    has_regs = (icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
  endfunction

  state_t      state, next_state;
  logic [1:0]  next_stat;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc;
  logic [3:0]  len;
  logic [3:0]  idx;
  logic [63:0] addr;

  logic        accept, fire, at_last;
  logic        acc_invalid, acc_range_err;
  logic [64:0] acc_end;
  logic [7:0]  sel_byte;
  logic [3:0]  valc_off;
  logic [2:0]  valc_byte;

  assign accept  = (state == IDLE) && bus.in_valid;
  assign fire    = (state == EMIT) && bus.out_ready;
  assign at_last = (idx == len - 4'd1);

  // The end address is computed with one extra bit so that the sum cannot
  // wrap around and pass the range check by mistake.
  assign acc_invalid   = (bus.in_icode >= 4'hC);
  assign acc_end       = {1'b0, addr} + 65'(instr_len(bus.in_icode));
  assign acc_range_err = (acc_end > 65'(MEM_BYTES));

  // Register the state and the status code.
  // NOTE: use non-blocking (<=) in clocked blocks, so every flop samples the values from before the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      stat  <= STAT_AOK;
    end else begin
      state <= next_state;
      stat  <= next_stat;
    end
  end

  // Next state: choose accept or reject in IDLE, and finish the instruction in EMIT.
  // NOTE: give every signal a default first, so no path through this block leaves a signal unassigned and infers a latch.
  always_comb begin
    next_state = state;
    next_stat  = stat;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (acc_invalid) begin
            next_state = ERROR;
            next_stat  = STAT_INS;
          end else if (acc_range_err) begin
            next_state = ERROR;
            next_stat  = STAT_ADR;
          end else begin
            next_state = EMIT;
          end
        end
      end
      EMIT: begin
        if (fire && at_last) begin
          if (icode == 4'h0) begin
            next_state = HALTED;
            next_stat  = STAT_HLT;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  // Latch the instruction fields on acceptance.
  // Step the byte index and the address on each accepted byte.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      icode       <= 4'h0;
      ifun        <= 4'h0;
      ra          <= 4'h0;
      rb          <= 4'h0;
      valc        <= 64'd0;
      len         <= 4'd0;
      idx         <= 4'd0;
      addr        <= BASE_ADDR;
      instr_count <= 32'd0;
    end else if (accept) begin
      icode <= bus.in_icode;
      ifun  <= bus.in_ifun;
      ra    <= bus.in_rA;
      rb    <= bus.in_rB;
      valc  <= bus.in_valC;
      len   <= instr_len(bus.in_icode);
      idx   <= 4'd0;
    end else if (fire) begin
      addr <= addr + 64'd1;
      idx  <= idx + 4'd1;
      if (at_last) instr_count <= instr_count + 32'd1;
    end
  end

  // Select the output byte: opcode first, then the register byte if present,
  // then valC least-significant byte first.
  always_comb begin
    valc_off  = has_regs(icode) ? 4'd2 : 4'd1;
    valc_byte = 3'(idx - valc_off);
    sel_byte  = 8'h00;
    if (idx == 4'd0)
      sel_byte = {icode, ifun};
    else if (has_regs(icode) && idx == 4'd1)
      sel_byte = {ra, rb};
    else
      sel_byte = valc[{valc_byte, 3'b000} +: 8];
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == EMIT);
  assign bus.out_byte  = (state == EMIT) ? sel_byte : 8'h00;
  assign bus.out_addr  = addr;
  assign bus.out_last  = (state == EMIT) && at_last;
  assign busy          = (state == EMIT);

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Testbench for y86_instr_encoder.
// A stimulus process issues instructions and pushes the expected bytes into a
// queue. A monitor process compares every byte the DUT presents.
module tb_y86_instr_encoder;

  localparam logic [63:0] BASE = 64'd0;
  localparam int          MEM  = 65;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        busy;
  logic [1:0]  stat;
  logic [31:0] instr_count;

  y86_instr_encoder_if bus();

  y86_instr_encoder #(.BASE_ADDR(BASE), .MEM_BYTES(MEM)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .busy        (busy),
    .stat        (stat),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  b;
    logic [63:0] a;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          n_seen = 0;
  int          ready_mode = 0;   // 0 always ready, 1 toggle, 2 random

  // Reference model state
  logic [63:0] m_addr;
  logic [1:0]  m_stat;
  logic [31:0] m_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: build the byte list from the encoding rules.
  // Bytes are emitted only when the whole instruction fits in memory.
  task automatic model_accept(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [63:0] vc);
    logic [7:0] bytes[$];
    exp_t       e;
    if (ic >= 4'hC) begin
      m_stat = 2'b11;
      return;
    end
    bytes.push_back({ic, fn});
    if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB})
      bytes.push_back({ra, rb});
    if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
      for (int k = 0; k < 8; k++) bytes.push_back(8'((vc >> (8 * k)) & 64'hFF));
    if (int'(m_addr) + bytes.size() > MEM) begin
      m_stat = 2'b10;
      return;
    end
    foreach (bytes[k]) begin
      e.b = bytes[k];
      e.a = m_addr + 64'(k);
      e.l = (k == bytes.size() - 1);
      sb.push_back(e);
    end
    m_addr  = m_addr + 64'(bytes.size());
    m_count = m_count + 32'd1;
    if (ic == 4'h0) m_stat = 2'b01;
  endtask

  // Drive out_ready according to the selected backpressure pattern.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare every presented byte against the head of the scoreboard.
  // A stalled byte is compared again on every cycle, which also checks that it holds stable.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && bus.out_valid) begin
        if (sb.size() == 0) begin
          fail_now($sformatf("unexpected_byte got %0h at addr %0d, expected none",
                             bus.out_byte, bus.out_addr));
        end else begin
          mon_e = sb[0];
          check("out_byte", 64'(bus.out_byte), 64'(mon_e.b));
          check("out_addr", bus.out_addr, mon_e.a);
          check("out_last", 64'(bus.out_last), 64'(mon_e.l));
          if (bus.out_ready) begin
            void'(sb.pop_front());
            n_seen++;
          end
        end
      end
    end
  end

  task automatic scramble_inputs();
    bus.in_icode = 4'($urandom);
    bus.in_ifun  = 4'($urandom);
    bus.in_rA    = 4'($urandom);
    bus.in_rB    = 4'($urandom);
    bus.in_valC  = {$urandom, $urandom};
  endtask

  // Offer one instruction. Starts and ends one time unit after a rising edge.
  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic [63:0] vc);
    int t = 0;
    while (!bus.in_ready) begin
      @(posedge clock);
      #1;
      t++;
      if (t > 300) begin
        fail_now("in_ready_timeout");
        return;
      end
    end
    bus.in_icode = ic;
    bus.in_ifun  = fn;
    bus.in_rA    = ra;
    bus.in_rB    = rb;
    bus.in_valC  = vc;
    bus.in_valid = 1'b1;
    @(posedge clock);
    model_accept(ic, fn, ra, rb, vc);
    #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
  endtask

  // Compare the architectural state with the reference model.
  task automatic check_state(input string tag);
    check({tag, "_stat"}, 64'(stat), 64'(m_stat));
    check({tag, "_instr_count"}, 64'(instr_count), 64'(m_count));
    check({tag, "_out_addr"}, bus.out_addr, m_addr);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(m_stat == 2'b00));
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Wait until all expected bytes have drained and the DUT is no longer busy.
  task automatic wait_done(input string tag);
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 400) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (t >= 400) begin
      fail_now({tag, "_drain_timeout"});
      sb.delete();
    end
    check_state(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    m_addr  = BASE;
    m_stat  = 2'b00;
    m_count = 32'd0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_byte", 64'(bus.out_byte), 64'd0);
    check("rst_stat", 64'(stat), 64'd0);
    check("rst_instr_count", 64'(instr_count), 64'd0);
    check("rst_out_addr", bus.out_addr, BASE);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int base;
    int t;
    logic [3:0] ic;
    bus.in_valid = 1'b0;
    scramble_inputs();
    @(posedge clock);
    #1;

    // irmovq from reset, no backpressure
    ready_mode = 0;
    do_reset();
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h64);
    wait_done("irmovq");

    // addq then jne. The register fields of jne are not emitted.
    do_reset();
    send(4'h6, 4'h0, 4'h0, 4'h1, 64'($urandom));
    send(4'h7, 4'h4, 4'($urandom), 4'($urandom), 64'h0A);
    wait_done("addq_jne");

    // halt is sticky, and further offers are ignored
    do_reset();
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
    wait_done("halt");
    bus.in_valid = 1'b1;
    bus.in_icode = 4'h3;
    repeat (5) begin
      @(posedge clock);
      #1;
      scramble_inputs();
    end
    bus.in_valid = 1'b0;
    check_state("halt_sticky");

    // invalid icode
    do_reset();
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'h1234);
    wait_done("invalid_icode");

    // address overflow after 60 bytes
    do_reset();
    for (int i = 0; i < 6; i++) send(4'h3, 4'h0, 4'hF, 4'(i), 64'($urandom));
    wait_done("fill60");
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h64);
    wait_done("overflow");

    // backpressure: out_ready toggles every cycle
    do_reset();
    ready_mode = 1;
    base = n_seen;
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123_4567_89AB_CDEF);
    wait_done("backpressure");
    check("bp_bytes_seen", 64'(n_seen - base), 64'd10);
    ready_mode = 0;

    // reset mid-emission after byte 4
    do_reset();
    base = n_seen;
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h64);
    t = 0;
    while (n_seen - base < 5 && t < 100) begin
      @(posedge clock);
      t++;
    end
    if (t >= 100) fail_now("mid_reset_wait_timeout");
    #1;
    do_reset();
    send(4'h6, 4'h1, 4'h3, 4'h4, 64'd0);
    wait_done("after_mid_reset");

    // randomized programs until a sticky state or a round limit
    for (int r = 0; r < 8; r++) begin
      do_reset();
      ready_mode = $urandom_range(0, 2);
      for (int n = 0; n < 30 && m_stat == 2'b00; n++) begin
        t = $urandom_range(0, 19);
        if (t == 0)      ic = 4'h0;
        else if (t == 1) ic = 4'($urandom_range(12, 15));
        else             ic = 4'($urandom_range(1, 11));
        send(ic, 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom});
        wait_done("random");
      end
    end
    ready_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/y86_instr_encoder.md
Name: y86_instr_encoder

Overview:
Encoder counterpart to the fetch stage. It accepts decoded Y86-64 instruction fields (icode, ifun, rA, rB, valC) over a valid/ready handshake. It serialises each instruction into its byte encoding and emits one byte per cycle, with a byte address, to the instruction-memory write port. It is used to load programs into instruction memory and to generate golden byte streams for fetch verification.

Parameters:
BASE_ADDR, 0, byte address of the first emitted byte after reset.
MEM_BYTES, 65, instruction memory size in bytes; valid addresses are 0..MEM_BYTES-1.

Ports:
clock  in  1  single clock; all state updates on rising edge.
reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  instruction fields valid.
in_ready  out  1  encoder can accept an instruction.
in_icode  in  4  instruction code.
in_ifun  in  4  function code.
in_rA  in  4  register A; ignored when the instruction has no register byte.
in_rB  in  4  register B; ignored when the instruction has no register byte.
in_valC  in  64  constant; ignored when the instruction has no valC.
out_valid  out  1  out_byte and out_addr are valid.
out_ready  in  1  memory side accepts the byte.
out_byte  out  8  encoded byte.
out_addr  out  64  byte address of out_byte.
out_last  out  1  out_byte is the final byte of the current instruction.
busy  out  1  an instruction is being emitted.
stat  out  2  status: 00 AOK, 01 HLT, 10 ADR, 11 INS.
instr_count  out  32  number of instructions fully emitted; wraps.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - Outputs: in_ready=1, out_valid=0, out_last=0, busy=0, out_byte=0, stat=00, instr_count=0.
  - Address counter and out_addr are set to BASE_ADDR.
  - Reset asserted mid-emission abandons the instruction immediately; no further bytes are emitted.
- States: IDLE, EMIT, HALTED, ERROR.
- Instruction classes:
  - regids only (2, 6, A, B): length 2.
  - valC only (7, 8): length 9.
  - regids and valC (3, 4, 5): length 10.
  - neither (0, 1, 9): length 1.
  - C..F are invalid.
- Byte order:
  - Byte 0 is {icode, ifun}.
  - Byte 1 is {rA, rB} when the instruction has a register byte.
  - The following 8 bytes are valC, little-endian (valC[7:0] first).
- IDLE:
  - in_ready=1.
  - On in_valid=1, the fields are latched and one of the following happens at the next edge:
  - icode in C..F: stat=11, go to ERROR, no bytes emitted.
  - addr+len > MEM_BYTES (compare computed without 64-bit overflow): stat=10, go to ERROR, no bytes emitted.
  - Otherwise: go to EMIT with byte index 0.
- EMIT:
  - in_ready=0, busy=1, out_valid=1.
  - out_byte is selected by the byte index; out_addr is the current address.
  - out_last=1 when index == len-1.
  - On out_valid && out_ready: address += 1 and index += 1.
  - On the last byte: instr_count += 1, then go to HALTED if icode==0 (stat=01), otherwise go to IDLE.
  - With out_ready=0: out_byte, out_addr and out_last hold stable.
- Timing:
  - First byte is presented 1 cycle after acceptance.
  - Throughput is 1 byte per cycle with out_ready held high.
  - Back-to-back instructions incur 1 idle cycle between them, for the return to IDLE.
- HALTED and ERROR:
  - Sticky until reset.
  - in_ready=0, out_valid=0; stat is held.
- Any change on in_* while in_ready=0 is ignored.
- The address counter never exceeds MEM_BYTES, because the range check runs at acceptance.

Test Plan:
- irmovq: icode=3, ifun=0, rA=F, rB=2, valC=0x64 at reset with out_ready=1 -> bytes 30 F2 64 00 00 00 00 00 00 00 at addrs 0..9; out_last on addr 9; instr_count=1; stat=00.
- addq then jne: addq icode=6, ifun=0, rA=0, rB=1, followed by jne icode=7, ifun=4, valC=0x0A -> 60 01 at addrs 0,1; then 74 0A 00 00 00 00 00 00 00 at addrs 2..10; rA/rB of jne are not emitted.
- halt: halt (icode=0) -> single byte 00; stat=01; in_ready stays 0; a further in_valid is ignored with no out_valid.
- Invalid and overflow cases:
  - icode=C -> stat=11, no bytes emitted.
  - Separately, with MEM_BYTES=65 and 60 bytes already written, irmovq -> stat=10, no bytes emitted, out_addr=60.
- Backpressure: out_ready toggled 0/1 every cycle during irmovq -> each byte held until accepted; total 10 accepted bytes in order; no duplicates or skips.
- Reset mid-emission: reset_n pulsed low after byte 4 of irmovq -> out_valid drops immediately; out_addr=BASE_ADDR; stat=00; instr_count=0; the next instruction encodes from BASE_ADDR.
